tone_scheduler: RTL and testbench

Sequences the alarm speaker datapath. It walks a note/beat ROM, holds each note for its beat length, and inserts a silent gap between notes. It also shares the single speaker between the alarm melody and short key-click beeps, and implements snooze. Its outputs drive the square-wave frequency generator (noteFreq) and its enable (toneEn).

---
 rtl/tone_scheduler_if.sv | 34 +++
 rtl/tone_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_tone_scheduler.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/tone_scheduler_if.sv
// tone_scheduler_if
//   Groups the control, melody ROM and speaker signals of the tone scheduler.
//   slave  : the scheduler itself (takes ticks/requests and ROM data, drives
//            the ROM address and the speaker controls)
//   master : the environment (tick sources, request sources, melody ROM,
//            frequency generator)
//   Signals: beatTick, secTick, alarmReq, beepReq, snooze, noteData,
//            beatData (towards scheduler); noteAddr, noteFreq, toneEn, busy,
//            snoozing, beepAck (from scheduler)
interface tone_scheduler_if;
    logic       beatTick;
    logic       secTick;
    logic       alarmReq;
    logic       beepReq;
    logic       snooze;
    logic [4:0] noteAddr;
    logic [9:0] noteData;
    logic [7:0] beatData;
    logic [9:0] noteFreq;
    logic       toneEn;
    logic       busy;
    logic       snoozing;
    logic       beepAck;

    modport master (
        output beatTick, secTick, alarmReq, beepReq, snooze, noteData, beatData,
        input  noteAddr, noteFreq, toneEn, busy, snoozing, beepAck
    );

    modport slave (
        input  beatTick, secTick, alarmReq, beepReq, snooze, noteData, beatData,
        output noteAddr, noteFreq, toneEn, busy, snoozing, beepAck
    );
endinterface

// File: rtl/tone_scheduler.sv
// tone_scheduler
//   Sequences the alarm speaker: walks the note/beat ROM, holds each note for
//   its beat count, inserts a silent gap between notes, shares the speaker
//   with key-click beeps and implements snooze.
//   Ports:
//     clk   - system clock
//     reset - synchronous active-high reset
//     bus   - tone_scheduler_if.slave (ticks, requests, ROM address/data,
//             noteFreq/toneEn to the frequency generator, busy, snoozing,
//             beepAck)
module tone_scheduler #(
    parameter int LAST_INDEX  = 25,
    parameter int REST_CODE   = 20,
    parameter int GAP_TICKS   = 2,
    parameter int BEEP_FREQ   = 988,
    parameter int BEEP_TICKS  = 5,
    parameter int SNOOZE_SECS = 300
) (
    input  logic            clk,
    input  logic            reset,
    tone_scheduler_if.slave bus
);

    // FETCH is split in two: the address cycle and the data-latch cycle
    // (ROM data is valid one clock after noteAddr).
    typedef enum logic [2:0] {
        IDLE,
        FETCH_ADDR,
        FETCH_DATA,
        PLAY,
        GAP,
        BEEP,
        SNOOZE
    } state_t;

    localparam logic [4:0]  LAST_IDX  = 5'(LAST_INDEX);
    localparam logic [9:0]  REST_FREQ = 10'(REST_CODE);
    localparam logic [9:0]  BEEP_CODE = 10'(BEEP_FREQ);
    localparam logic [15:0] GAP_LOAD  = 16'(GAP_TICKS);
    localparam logic [15:0] BEEP_LOAD = 16'(BEEP_TICKS);
    localparam logic [15:0] SNZ_LOAD  = 16'(SNOOZE_SECS);

    state_t      state, stateNext;
    logic [4:0]  index, indexNext;
    logic [15:0] count, countNext;
    logic [9:0]  freq, freqNext;
    logic        tone, toneNext;
    logic        ack, ackNext;
    logic        pending, pendingNext;

    function automatic logic [4:0] nextIndex(input logic [4:0] idx);
        return (idx == LAST_IDX) ? 5'd0 : idx + 5'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            index   <= '0;
            count   <= '0;
            freq    <= '0;
            tone    <= 1'b0;
            ack     <= 1'b0;
            pending <= 1'b0;
        end else begin
            state   <= stateNext;
            index   <= indexNext;
            count   <= countNext;
            freq    <= freqNext;
            tone    <= toneNext;
            ack     <= ackNext;
            pending <= pendingNext;
        end
    end

    always_comb begin
        stateNext   = state;
        indexNext   = index;
        countNext   = count;
        freqNext    = freq;
        toneNext    = tone;
        ackNext     = 1'b0;
        // Clicks are dropped while a beep is already sounding.
        pendingNext = pending | (bus.beepReq && (state != BEEP));

        case (state)
            IDLE: begin
                toneNext = 1'b0;
                if (bus.alarmReq) begin
                    // The alarm swallows any queued click silently.
                    stateNext   = FETCH_ADDR;
                    indexNext   = '0;
                    pendingNext = 1'b0;
                end else if (pending) begin
                    stateNext = BEEP;
                    freqNext  = BEEP_CODE;
                    toneNext  = 1'b1;
                    countNext = BEEP_LOAD;
                end
            end

            FETCH_ADDR, FETCH_DATA, PLAY, GAP: begin
                // Alarm withdrawal beats snooze when both happen together.
                if (!bus.alarmReq) begin
                    stateNext = IDLE;
                    toneNext  = 1'b0;
                    indexNext = '0;
                end else if (bus.snooze) begin
                    stateNext = SNOOZE;
                    toneNext  = 1'b0;
                    countNext = SNZ_LOAD;
                end else if (state == FETCH_ADDR) begin
                    stateNext = FETCH_DATA;
                end else if (state == FETCH_DATA) begin
                    stateNext = PLAY;
                    freqNext  = bus.noteData;
                    toneNext  = (bus.noteData != REST_FREQ);
                    countNext = (bus.beatData == 8'd0) ? 16'd1 : {8'd0, bus.beatData};
                end else if (bus.beatTick) begin
                    if (count <= 16'd1) begin
                        toneNext = 1'b0;
                        if (state == PLAY && GAP_TICKS != 0) begin
                            stateNext = GAP;
                            countNext = GAP_LOAD;
                        end else begin
                            stateNext = FETCH_ADDR;
                            indexNext = nextIndex(index);
                        end
                    end else begin
                        countNext = count - 16'd1;
                    end
                end
            end

            BEEP: begin
                if (bus.alarmReq) begin
                    stateNext   = FETCH_ADDR;
                    indexNext   = '0;
                    toneNext    = 1'b0;
                    pendingNext = 1'b0;
                end else if (bus.beatTick) begin
                    if (count <= 16'd1) begin
                        stateNext   = IDLE;
                        toneNext    = 1'b0;
                        ackNext     = 1'b1;
                        pendingNext = 1'b0;
                    end else begin
                        countNext = count - 16'd1;
                    end
                end
            end

            SNOOZE: begin
                if (!bus.alarmReq) begin
                    stateNext = IDLE;
                    indexNext = '0;
                end else if (bus.secTick) begin
                    if (count <= 16'd1) begin
                        stateNext = FETCH_ADDR;
                        indexNext = '0;
                    end else begin
                        countNext = count - 16'd1;
                    end
                end
            end

            default: begin
                stateNext = IDLE;
                toneNext  = 1'b0;
            end
        endcase
    end

    assign bus.noteAddr = index;
    assign bus.noteFreq = freq;
    assign bus.toneEn   = tone;
    assign bus.busy     = (state != IDLE);
    assign bus.snoozing = (state == SNOOZE);
    assign bus.beepAck  = ack;

endmodule

// File: tb/tb_tone_scheduler.sv
// tb_tone_scheduler
//   Directed bench for tone_scheduler: all ticks are generated by hand so each
//   expected value follows directly from the beat/gap/snooze counts.
module tb_tone_scheduler;

    logic clk;
    logic reset;
    int   vecCnt;
    int   errCnt;

    logic [9:0] romFreq [32];
    logic [7:0] romBeat [32];

    tone_scheduler_if bus();

    tone_scheduler #(
        .LAST_INDEX (25),
        .REST_CODE  (20),
        .GAP_TICKS  (2),
        .BEEP_FREQ  (988),
        .BEEP_TICKS (5),
        .SNOOZE_SECS(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous melody ROM: data valid one clock after the address.
    always @(posedge clk) begin
        bus.noteData <= romFreq[bus.noteAddr];
        bus.beatData <= romBeat[bus.noteAddr];
    end

    task automatic checkEq(input string tag, input int got, input int exp);
        vecCnt++;
        if (got != exp) begin
            errCnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat();
        bus.beatTick = 1'b1;
        cyc();
        bus.beatTick = 1'b0;
    endtask

    task automatic sec();
        bus.secTick = 1'b1;
        cyc();
        bus.secTick = 1'b0;
    endtask

    // Starts in the address cycle of note i; ends in the address cycle of
    // the following note.
    task automatic playNote(input int i);
        int eff;
        eff = (romBeat[i] == 8'd0) ? 1 : int'(romBeat[i]);
        checkEq("noteAddr", int'(bus.noteAddr), i);
        cyc();
        cyc();
        checkEq("noteFreq", int'(bus.noteFreq), int'(romFreq[i]));
        checkEq("toneEn play", int'(bus.toneEn), (romFreq[i] == 10'd20) ? 0 : 1);
        repeat (eff) beat();
        checkEq("toneEn gap", int'(bus.toneEn), 0);
        repeat (2) beat();
    endtask

    initial begin
        vecCnt = 0;
        errCnt = 0;
        for (int i = 0; i < 32; i++) begin
            romFreq[i] = 10'(100 + i * 10);
            romBeat[i] = 8'd1;
        end
        romFreq[0] = 10'd660; romBeat[0] = 8'd2;
        romFreq[1] = 10'd784; romBeat[1] = 8'd1;
        romFreq[2] = 10'd20;  romBeat[2] = 8'd1;
        romBeat[25] = 8'd0;

        bus.beatTick = 1'b0;
        bus.secTick  = 1'b0;
        bus.alarmReq = 1'b0;
        bus.beepReq  = 1'b0;
        bus.snooze   = 1'b0;
        reset        = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;

        checkEq("rst noteAddr", int'(bus.noteAddr), 0);
        checkEq("rst noteFreq", int'(bus.noteFreq), 0);
        checkEq("rst toneEn", int'(bus.toneEn), 0);
        checkEq("rst busy", int'(bus.busy), 0);
        checkEq("rst snoozing", int'(bus.snoozing), 0);
        checkEq("rst beepAck", int'(bus.beepAck), 0);

        // First note: 660 for 2 beats, then a 2-beat gap.
        bus.alarmReq = 1'b1;
        cyc();
        checkEq("alarm busy", int'(bus.busy), 1);
        checkEq("alarm addr", int'(bus.noteAddr), 0);
        cyc();
        cyc();
        checkEq("n0 freq", int'(bus.noteFreq), 660);
        checkEq("n0 tone", int'(bus.toneEn), 1);
        beat();
        checkEq("n0 tone b1", int'(bus.toneEn), 1);
        beat();
        checkEq("n0 tone b2", int'(bus.toneEn), 0);
        checkEq("n0 freq hold", int'(bus.noteFreq), 660);
        beat();
        checkEq("n0 gap1 addr", int'(bus.noteAddr), 0);
        beat();

        // Rest note, ordinary notes, zero-beat note at 25 and wrap to 0.
        for (int i = 1; i <= 25; i++) playNote(i);
        checkEq("wrap addr", int'(bus.noteAddr), 0);
        cyc();
        cyc();
        checkEq("wrap freq", int'(bus.noteFreq), 660);
        checkEq("wrap tone", int'(bus.toneEn), 1);

        // Alarm withdrawn mid-note.
        bus.alarmReq = 1'b0;
        cyc();
        checkEq("drop tone", int'(bus.toneEn), 0);
        checkEq("drop busy", int'(bus.busy), 0);
        checkEq("drop freq hold", int'(bus.noteFreq), 660);

        // Key-click beep from idle.
        bus.beepReq = 1'b1;
        cyc();
        bus.beepReq = 1'b0;
        cyc();
        checkEq("beep freq", int'(bus.noteFreq), 988);
        checkEq("beep tone", int'(bus.toneEn), 1);
        checkEq("beep busy", int'(bus.busy), 1);
        repeat (4) beat();
        checkEq("beep tone b4", int'(bus.toneEn), 1);
        checkEq("beep ack b4", int'(bus.beepAck), 0);
        beat();
        checkEq("beep ack", int'(bus.beepAck), 1);
        checkEq("beep end tone", int'(bus.toneEn), 0);
        checkEq("beep end busy", int'(bus.busy), 0);
        cyc();
        checkEq("beep ack pulse", int'(bus.beepAck), 0);

        // Snooze mid-note, resume after 3 seconds.
        bus.alarmReq = 1'b1;
        cyc();
        cyc();
        cyc();
        checkEq("snz pre tone", int'(bus.toneEn), 1);
        beat();
        bus.snooze = 1'b1;
        cyc();
        bus.snooze = 1'b0;
        checkEq("snz tone", int'(bus.toneEn), 0);
        checkEq("snz flag", int'(bus.snoozing), 1);
        sec();
        sec();
        checkEq("snz flag s2", int'(bus.snoozing), 1);
        sec();
        checkEq("snz done flag", int'(bus.snoozing), 0);
        checkEq("snz done addr", int'(bus.noteAddr), 0);
        checkEq("snz done busy", int'(bus.busy), 1);
        cyc();
        cyc();
        checkEq("snz resume freq", int'(bus.noteFreq), 660);
        checkEq("snz resume tone", int'(bus.toneEn), 1);

        // Alarm rising mid-beep aborts the beep.
        bus.alarmReq = 1'b0;
        cyc();
        bus.beepReq = 1'b1;
        cyc();
        bus.beepReq = 1'b0;
        cyc();
        checkEq("abort beep tone", int'(bus.toneEn), 1);
        checkEq("abort beep freq", int'(bus.noteFreq), 988);
        beat();
        beat();
        bus.alarmReq = 1'b1;
        cyc();
        checkEq("abort ack", int'(bus.beepAck), 0);
        checkEq("abort tone", int'(bus.toneEn), 0);
        checkEq("abort addr", int'(bus.noteAddr), 0);
        cyc();
        checkEq("abort ack2", int'(bus.beepAck), 0);
        cyc();
        checkEq("abort melody freq", int'(bus.noteFreq), 660);
        bus.alarmReq = 1'b0;
        cyc();
        cyc();
        checkEq("no stale beep", int'(bus.busy), 0);

        // Reset in the gap after note 7.
        bus.alarmReq = 1'b1;
        cyc();
        for (int i = 0; i <= 6; i++) playNote(i);
        checkEq("n7 addr", int'(bus.noteAddr), 7);
        cyc();
        cyc();
        beat();
        checkEq("n7 gap tone", int'(bus.toneEn), 0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checkEq("gaprst addr", int'(bus.noteAddr), 0);
        checkEq("gaprst freq", int'(bus.noteFreq), 0);
        checkEq("gaprst tone", int'(bus.toneEn), 0);
        checkEq("gaprst busy", int'(bus.busy), 0);
        cyc();
        checkEq("retrig busy", int'(bus.busy), 1);
        checkEq("retrig addr", int'(bus.noteAddr), 0);
        cyc();
        cyc();
        checkEq("retrig freq", int'(bus.noteFreq), 660);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
